hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 IDEX_MemRead  input  1  instruction in EX is a load.
REQ-005 IDEX_Rt  input  5  load destination register in EX.
REQ-006 IFID_Rs, IFID_Rt  input  5 each  source registers of the instruction in ID.
REQ-007 IFID_UsesRt  input  1  ID instruction reads Rt.
REQ-008 EXMEM_Branch, EXMEM_Zero  input  1 each  branch flag and zero flag held in the EX/MEM register.
REQ-009 EXMEM_BranchAddress  input  32  branch target held in the EX/MEM register.
REQ-010 EXMEM_MemRead, EXMEM_MemWrite  input  1 each  MEM-stage memory request.
REQ-011 mem_ready  input  1  data memory has completed the current access this cycle.
REQ-012 PCWrite, IFID_Write  output  1 each  update enables for the PC and IF/ID.
REQ-013 IDEX_Flush, IFID_Flush, EXMEM_Flush  output  1 each  bubble inserts; each is wired to the flush input of its pipeline register.
REQ-014 PipeHold  output  1  freezes ID/EX, EX/MEM and MEM/WB.
REQ-015 PCSrc  output  1  selects BranchTarget as the next PC.
REQ-016 BranchTarget  output  32  the next PC when PCSrc=1.
REQ-017 MemTimeout  output  1  sticky memory-timeout error flag.
REQ-018 StallCount, FlushCount  output  16 each  performance counters.

Function
REQ-019 These terms SHALL be used in the requirements below:
- mem_req = EXMEM_MemRead | EXMEM_MemWrite
- mem_wait = mem_req & ~mem_ready
- br_taken = EXMEM_Branch & EXMEM_Zero
- load_use = IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & IDEX_Rt == IFID_Rt))
REQ-020 Control outputs SHALL be combinational from the inputs and state. The counters and MemTimeout SHALL be registered.
REQ-021 Event priority SHALL be, highest first: reset, mem_wait, br_taken, load_use, normal.
REQ-022 On mem_wait, the block SHALL drive:
- PipeHold=1, PCWrite=0, IFID_Write=0
- all flushes=0, PCSrc=0
REQ-023 On br_taken without mem_wait, the block SHALL drive:
- PCSrc=1, BranchTarget=EXMEM_BranchAddress, PCWrite=1
- IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1
- PipeHold=0
REQ-024 On load_use without mem_wait or br_taken, the block SHALL drive:
- PCWrite=0, IFID_Write=0, IDEX_Flush=1
- all other flushes=0, PipeHold=0
REQ-025 In the normal case, the block SHALL drive:
- PCWrite=1, IFID_Write=1
- all flushes=0, PipeHold=0, PCSrc=0
REQ-026 BranchTarget SHALL equal EXMEM_BranchAddress whenever PCSrc=1, and SHALL be 0 otherwise.
REQ-027 The FSM SHALL have three states:
- RUN
- WAIT: a memory access is outstanding
- STUCK: timed out
REQ-028 FSM transitions SHALL be:
- RUN -> WAIT on mem_wait
- WAIT -> RUN on mem_ready
- WAIT -> STUCK when WaitCnt reaches 15 with mem_ready=0
- STUCK -> RUN on mem_ready
REQ-029 WaitCnt SHALL be a 4-bit counter that clears on entry to RUN and increments each cycle in WAIT.
REQ-030 MemTimeout SHALL set on the WAIT->STUCK transition and clear only on reset.
REQ-031 In STUCK, the hold behaviour of REQ-022 SHALL continue while mem_wait=1.
REQ-032 A mem_ready=1 in the first cycle of mem_req SHALL produce no hold and no state change.
REQ-033 StallCount SHALL increment by 1 in each cycle where load_use wins priority or mem_wait is asserted.
REQ-034 FlushCount SHALL increment by 1 in each cycle where br_taken wins priority.
REQ-035 Both counters SHALL saturate at 16'hFFFF.
REQ-036 load_use with IDEX_Rt=0 SHALL NOT stall.
REQ-037 When br_taken and load_use occur in the same cycle, br_taken SHALL win and IDEX_Flush SHALL be 1.

Reset
REQ-038 With reset=1 at a clk edge, the block SHALL go to:
- state=RUN, WaitCnt=0, MemTimeout=0
- StallCount=0, FlushCount=0
REQ-039 While reset=1, all flush outputs SHALL be driven 1, PCWrite=0, IFID_Write=0, PipeHold=0 and PCSrc=0.
REQ-040 Reset in WAIT or STUCK SHALL abort the access tracking with no residual hold.

Verification
REQ-041 The bench SHALL cover load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle -> PCWrite=0, IFID_Write=0, IDEX_Flush=1; StallCount 0->1.
REQ-042 The bench SHALL cover a taken branch: EXMEM_Branch=1, EXMEM_Zero=1, EXMEM_BranchAddress=0x00000040 -> PCSrc=1, BranchTarget=0x40, three flushes=1; FlushCount=1.
REQ-043 The bench SHALL cover a memory wait: EXMEM_MemRead=1 with mem_ready=0 for 3 cycles, then 1 -> PipeHold=1 for 3 cycles, RUN on the 4th edge, StallCount=3, MemTimeout=0.
REQ-044 The bench SHALL cover timeout: mem_ready=0 for 20 cycles -> STUCK after 16 cycles, MemTimeout=1 and held until reset, PipeHold=1 throughout.
REQ-045 The bench SHALL cover priority: br_taken, load_use and mem_wait asserted together -> hold only, no flushes; after mem_ready=1, the branch flush is taken.
REQ-046 The bench SHALL cover saturation and reset: force 65540 load_use cycles -> StallCount=0xFFFF; assert reset in WAIT -> RUN and counters 0 next cycle.

Source files
------------

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard, branch-flush and memory-wait control
module hazard_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRt,
    input  logic        EXMEM_Branch,
    input  logic        EXMEM_Zero,
    input  logic [31:0] EXMEM_BranchAddress,
    input  logic        EXMEM_MemRead,
    input  logic        EXMEM_MemWrite,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IDEX_Flush,
    output logic        IFID_Flush,
    output logic        EXMEM_Flush,
    output logic        PipeHold,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic        MemTimeout,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic [1:0] {RUN, WAIT, STUCK} state_t;

    state_t     state;
    logic [3:0] wait_cnt;

    logic mem_req;
    logic mem_wait;
    logic br_taken;
    logic load_use;
    logic stall_evt;
    logic flush_evt;

    assign mem_req   = EXMEM_MemRead | EXMEM_MemWrite;
    assign mem_wait  = mem_req & ~mem_ready;
    assign br_taken  = EXMEM_Branch & EXMEM_Zero;
    assign load_use  = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                       ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));
    // A memory wait counts as a stall even though it outranks load-use
    assign stall_evt = ~reset & (mem_wait | (load_use & ~br_taken));
    assign flush_evt = ~reset & ~mem_wait & br_taken;

    // Pipeline control: priority reset > mem_wait > branch > load-use > normal
    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Flush   = 1'b0;
        IFID_Flush   = 1'b0;
        EXMEM_Flush  = 1'b0;
        PipeHold     = 1'b0;
        PCSrc        = 1'b0;
        BranchTarget = 32'd0;
        if (reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Flush  = 1'b1;
            IFID_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (mem_wait) begin
            PipeHold   = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
        end else if (br_taken) begin
            PCSrc        = 1'b1;
            BranchTarget = EXMEM_BranchAddress;
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            EXMEM_Flush  = 1'b1;
        end else if (load_use) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end
    end

    // Memory access tracker; timeout fires on the edge wait_cnt reaches 15
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            wait_cnt   <= 4'd0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= 4'd0;
                    if (mem_wait) state <= WAIT;
                end
                WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                        if (wait_cnt == 4'd14) begin
                            state      <= STUCK;
                            MemTimeout <= 1'b1;
                        end
                    end
                end
                STUCK: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= 4'd0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= 16'd0;
            FlushCount <= 16'd0;
        end else begin
            if (stall_evt && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
            if (flush_evt && FlushCount != 16'hFFFF) FlushCount <= FlushCount + 16'd1;
        end
    end

endmodule
